display_scanner: RTL and testbench

DISPLAY_SCANNER -- requirements
Module: display_scanner

---
 rtl/display_scanner_pkg.sv | 13 +
 rtl/scan_tick_gen.sv | 34 +++
 rtl/display_scanner.sv | 107 ++++++++++
 tb/tb_display_scanner.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/display_scanner_pkg.sv
// Shared constants for the multiplexed 7-segment display scanner.
//   DefNumDigits / DefPrescale / DefGuard : default parameter values
//   DigitSelDark                          : active-low digit enable with every digit off
package display_scanner_pkg;

  localparam int unsigned MaxDigits    = 8;
  localparam int unsigned DefNumDigits = 8;
  localparam int unsigned DefPrescale  = 50000;
  localparam int unsigned DefGuard     = 2;

  localparam logic [MaxDigits-1:0] DigitSelDark = '1;

endpackage

// File: rtl/scan_tick_gen.sv
// Slot prescaler for the display scanner.
//   clk, rst_n : clock and asynchronous active-low reset
//   cnt        : position inside the current digit slot, 0..PRESCALE-1
//   tick       : high in the last cycle of a slot (cnt == PRESCALE-1)
module scan_tick_gen
  import display_scanner_pkg::*;
#(
  parameter int unsigned PRESCALE = DefPrescale,
  parameter int unsigned CntW     = $clog2(PRESCALE)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [CntW-1:0] cnt,
  output logic            tick
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CntW'(PRESCALE - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed scanner for NUM_DIGITS common-anode 7-segment digits.
//   clk, rst_n  : clock and asynchronous active-low reset
//   value_in    : hex value, nibble i shown on digit i
//   load        : capture value_in; takes effect from the next frame start
//   lz_en       : suppress leading zeros (digit 0 always shown)
//   blank_mask  : bit i forces digit i dark
//   hex_digit   : nibble of the digit currently scanned
//   digit_sel   : active-low one-hot digit enable, all ones when dark
//   digit_blank : current slot is dark (guard, mask or suppression)
//   frame_start : pulse in the first cycle of digit 0's slot
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = DefNumDigits,
  parameter int unsigned PRESCALE   = DefPrescale,
  parameter int unsigned GUARD      = DefGuard
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic                    lz_en,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [3:0]              hex_digit,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    digit_blank,
  output logic                    frame_start
);

  localparam int unsigned CntW = $clog2(PRESCALE);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CntW-1:0] cnt;
  logic            tick;

  scan_tick_gen #(
    .PRESCALE (PRESCALE),
    .CntW     (CntW)
  ) u_scan_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (cnt),
    .tick  (tick)
  );

  logic [IdxW-1:0]                idx_q;
  logic [NUM_DIGITS-1:0][3:0]     shadow_q, pending_q;
  logic                           pending_valid_q;
  logic                           frame_end;

  assign frame_end = tick && (idx_q == IdxW'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (tick) begin
      idx_q <= frame_end ? '0 : idx_q + 1'b1;
    end
  end

  // Loads are staged in pending and only promoted to shadow on the frame
  // boundary, so a frame is always drawn from one value. A load landing on
  // the boundary itself bypasses pending and is the newest value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
    end else if (frame_end) begin
      if (load) begin
        shadow_q <= value_in;
      end else if (pending_valid_q) begin
        shadow_q <= pending_q;
      end
      pending_valid_q <= 1'b0;
    end else if (load) begin
      pending_q       <= value_in;
      pending_valid_q <= 1'b1;
    end
  end

  // Digit i>0 is a leading zero when it and every higher nibble are zero.
  logic [4*NUM_DIGITS-1:0] shadow_flat;
  logic [NUM_DIGITS-1:0]   suppress;

  assign shadow_flat = shadow_q;

  always_comb begin
    suppress = '0;
    for (int i = 1; i < int'(NUM_DIGITS); i++) begin
      suppress[i] = lz_en && ((shadow_flat >> (4 * i)) == '0);
    end
  end

  logic in_guard;
  logic dark;

  assign in_guard = (32'(cnt) < GUARD);
  assign dark     = in_guard || blank_mask[idx_q] || suppress[idx_q];

  assign hex_digit   = shadow_q[idx_q];
  assign digit_blank = dark;
  assign digit_sel   = dark ? DigitSelDark[NUM_DIGITS-1:0]
                            : ~(NUM_DIGITS'(1) << idx_q);
  assign frame_start = (idx_q == '0) && (cnt == '0);

endmodule

// File: tb/tb_display_scanner.sv
module tb_display_scanner;

  localparam int unsigned ND = 8;
  localparam int unsigned PS = 4;
  localparam int unsigned GD = 1;
  localparam int unsigned FRAME = ND * PS;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [4*ND-1:0] value_in = '0;
  logic            load = 1'b0;
  logic            lz_en = 1'b0;
  logic [ND-1:0]   blank_mask = '0;
  logic [3:0]      hex_digit;
  logic [ND-1:0]   digit_sel;
  logic            digit_blank;
  logic            frame_start;

  display_scanner #(
    .NUM_DIGITS (ND),
    .PRESCALE   (PS),
    .GUARD      (GD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value_in    (value_in),
    .load        (load),
    .lz_en       (lz_en),
    .blank_mask  (blank_mask),
    .hex_digit   (hex_digit),
    .digit_sel   (digit_sel),
    .digit_blank (digit_blank),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: cycle number since reset release, the value shown in
  // the current frame, and the most recent load seen during this frame.
  int          t;
  logic [31:0] m_shown;
  logic [31:0] m_last;
  bit          m_has;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d: got %h expected %h", name, t, act, exp);
    end
  endtask

  task automatic model_check();
    int          cnt, idx;
    logic [3:0]  nib;
    bit          supp, dark;
    logic [7:0]  sel;
    cnt  = t % PS;
    idx  = (t / PS) % ND;
    nib  = m_shown[4*idx +: 4];
    supp = lz_en && (idx > 0) && ((m_shown >> (4 * idx)) == 0);
    dark = (cnt < GD) || blank_mask[idx] || supp;
    sel  = dark ? 8'hFF : ~(8'h01 << idx);
    chk("model_hex", 32'(hex_digit), 32'(nib));
    chk("model_sel", 32'(digit_sel), 32'(sel));
    chk("model_blank", 32'(digit_blank), 32'(dark));
    chk("model_fs", 32'(frame_start), 32'((t % FRAME) == 0));
  endtask

  // One clock cycle: drive inputs, compare against the model, advance.
  task automatic step(input logic ld, input logic [31:0] val);
    load     = ld;
    value_in = val;
    #1;
    model_check();
    if (ld) begin
      m_last = val;
      m_has  = 1'b1;
    end
    // The last load of a frame becomes the next frame's value.
    if ((t % FRAME) == FRAME - 1 && m_has) begin
      m_shown = m_last;
      m_has   = 1'b0;
    end
    @(posedge clk);
    #1;
    load = 1'b0;
    t++;
  endtask

  task automatic run_to(input int target);
    while (t < target) step(1'b0, 32'h0);
  endtask

  task automatic probe(input string name, input logic [7:0] sel, input logic [3:0] hex,
                       input logic blank, input logic fs);
    #1;
    chk({name, "_sel"}, 32'(digit_sel), 32'(sel));
    chk({name, "_hex"}, 32'(hex_digit), 32'(hex));
    chk({name, "_blank"}, 32'(digit_blank), 32'(blank));
    chk({name, "_fs"}, 32'(frame_start), 32'(fs));
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    load       = 1'b0;
    value_in   = '0;
    lz_en      = 1'b0;
    blank_mask = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    #1;
    t       = 0;
    m_shown = '0;
    m_last  = '0;
    m_has   = 1'b0;
  endtask

  typedef struct {
    int         cyc;
    logic [7:0] sel;
    logic [3:0] hex;
    logic       blank;
    logic       fs;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int vi;

    // Directed table: reset release, then load 1234ABCD at cycle 10.
    vecs.push_back('{0,  8'hFF, 4'h0, 1'b1, 1'b1});
    vecs.push_back('{1,  8'hFE, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{3,  8'hFE, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{4,  8'hFF, 4'h0, 1'b1, 1'b0});
    vecs.push_back('{5,  8'hFD, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{10, 8'hFB, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{31, 8'h7F, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{32, 8'hFF, 4'hD, 1'b1, 1'b1});
    vecs.push_back('{33, 8'hFE, 4'hD, 1'b0, 1'b0});
    vecs.push_back('{37, 8'hFD, 4'hC, 1'b0, 1'b0});
    vecs.push_back('{60, 8'hFF, 4'h1, 1'b1, 1'b0});
    vecs.push_back('{61, 8'h7F, 4'h1, 1'b0, 1'b0});

    do_reset();
    vi = 0;
    for (int c = 0; c < 64; c++) begin
      if (vi < vecs.size() && vecs[vi].cyc == c) begin
        probe("table", vecs[vi].sel, vecs[vi].hex, vecs[vi].blank, vecs[vi].fs);
        vi++;
      end
      step(c == 10, (c == 10) ? 32'h1234ABCD : 32'h0);
    end

    // Last load in a frame wins; a load on the boundary tick beats pending.
    do_reset();
    run_to(5);   step(1'b1, 32'h11111111);
    run_to(20);  step(1'b1, 32'h22222222);
    run_to(40);  probe("last_wins", 8'hFF, 4'h2, 1'b1, 1'b0);
    run_to(50);  step(1'b1, 32'h44444444);
    run_to(63);  step(1'b1, 32'h33333333);
    probe("boundary_load", 8'hFF, 4'h3, 1'b1, 1'b1);
    run_to(69);  probe("boundary_load_d1", 8'hFD, 4'h3, 1'b0, 1'b0);

    // Leading-zero suppression with 00000050.
    do_reset();
    step(1'b1, 32'h00000050);
    run_to(32);
    lz_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_to(32 + 4 * i + 1);
      if (i == 0)      probe("lz_on", 8'hFE, 4'h0, 1'b0, 1'b0);
      else if (i == 1) probe("lz_on", 8'hFD, 4'h5, 1'b0, 1'b0);
      else             probe("lz_on", 8'hFF, 4'h0, 1'b1, 1'b0);
    end
    run_to(64);
    lz_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] s;
      s = ~(8'h01 << i);
      run_to(64 + 4 * i + 1);
      probe("lz_off", s, (i == 1) ? 4'h5 : 4'h0, 1'b0, 1'b0);
    end

    // All zero, suppression on, digit 0 masked: whole frame dark.
    step(1'b1, 32'h0);
    run_to(96);
    lz_en      = 1'b1;
    blank_mask = 8'h01;
    for (int c = 96; c < 128; c++) begin
      #1;
      chk("all_dark_sel", 32'(digit_sel), 32'h000000FF);
      chk("all_dark_blank", 32'(digit_blank), 32'h1);
      step(1'b0, 32'h0);
    end

    // Asynchronous reset mid-cycle during digit 5 with a load pending.
    do_reset();
    run_to(3);   step(1'b1, 32'hABCD0123);
    run_to(52);  step(1'b1, 32'h99999999);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sel", 32'(digit_sel), 32'h000000FF);
    chk("async_rst_hex", 32'(hex_digit), 32'h0);
    chk("async_rst_blank", 32'(digit_blank), 32'h1);
    chk("async_rst_fs", 32'(frame_start), 32'h1);
    @(negedge clk);
    rst_n   = 1'b1;
    #1;
    t       = 0;
    m_shown = '0;
    m_has   = 1'b0;
    run_to(32);
    probe("no_stale_pending", 8'hFF, 4'h0, 1'b1, 1'b1);
    run_to(70);

    // Randomised traffic against the model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      logic [31:0] v;
      if ((c % FRAME) == 0) begin
        blank_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      end
      if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
      v = $urandom >> $urandom_range(0, 31);
      step($urandom_range(0, 5) == 0, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
